// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter and its planned receiver.
// Frame state encoding, parity-mode constants and frame-length helper.
package uart_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_WAIT,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic int frame_bits(
        input int data_bits,
        input int parity_mode,
        input int stop_bits
    );
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_baud_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1, pulses bit_tick on the last count.
// clear forces the count back to zero so every state starts a fresh bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter (data width, parity, stop bits, baud divisor).
// Optional line-break request enabled by defining UART_TX_BREAK_EN.
module uart_tx_cfg
    import uart_cfg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    input  logic                 hold,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_req,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 data_out
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_par
        $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic ODD       = (PARITY_MODE == PAR_ODD);
    localparam logic HAS_PAR   = (PARITY_MODE != PAR_NONE);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    tx_state_e            state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic                 stop_idx, stop_n;
    logic                 par_q, par_n;
    logic                 done_n;
    logic                 line_n;
    logic                 bit_tick;
    logic                 baud_clr;
    logic                 brk_active;

`ifdef UART_TX_BREAK_EN
    assign brk_active = break_req && (state == IDLE);
`else
    assign brk_active = 1'b0;
`endif

    // Counter is held at zero while waiting so START always gets a full bit.
    assign baud_clr = (state_n != state) || (state == IDLE) ||
                      (state == HOLD_WAIT);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock   (clock),
        .reset   (reset),
        .clear   (baud_clr),
        .bit_tick(bit_tick)
    );

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bit_n   = bit_idx;
        stop_n  = stop_idx;
        par_n   = par_q;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (send && !brk_active) begin
                    shreg_n = data_in;
                    par_n   = (^data_in) ^ ODD;
                    bit_n   = '0;
                    stop_n  = 1'b0;
                    state_n = hold ? HOLD_WAIT : START;
                end
            end
            HOLD_WAIT: begin
                if (!hold) state_n = START;
            end
            START: begin
                if (bit_tick) state_n = DATA;
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_BIT) begin
                        state_n = HAS_PAR ? PARITY : STOP;
                    end else begin
                        bit_n   = bit_idx + 1'b1;
                        shreg_n = shreg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_n = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_idx == LAST_STOP) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line value is computed for the state being entered, then registered.
        unique case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shreg_n[0];
            PARITY:  line_n = par_n;
            default: line_n = 1'b1;
        endcase
        if (brk_active && state_n == IDLE) line_n = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_q    <= 1'b0;
            done     <= 1'b0;
            data_out <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_idx  <= bit_n;
            stop_idx <= stop_n;
            par_q    <= par_n;
            done     <= done_n;
            data_out <= line_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART serial transmitter; successor to the fixed 8N1 transmitter on the FPGA-to-PC link.
- Data width, parity mode, stop-bit count and baud divisor are set at elaboration.
- Baud timing is internal; no external timer block is needed.
- Sits between host logic (send/busy handshake) and the board UART TX pin; keeps the receiver-driven hold handshake.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2
DATA_BITS, 8, payload bits per frame, sent LSB first; legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; 1 or 2

Ports:
clock  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-high system reset
data_in  input  DATA_BITS  payload; sampled only on an accepted send
send  input  1  request to transmit data_in
hold  input  1  receiver handshake; while high, no new frame starts
busy  output  1  high from acceptance until the frame completes; host must not expect send to be taken while high
done  output  1  one-cycle pulse when the last stop bit ends
data_out  output  1  serial line; idle high

Behaviour:
- Reset (async, immediate): data_out=1, busy=0, done=0, state=IDLE, all counters 0. Reset mid-frame abandons the frame and returns the line high at once.
- States: IDLE, HOLD_WAIT, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_MODE=0.
- Accept: send=1 and busy=0 at a clock edge latches data_in into a shift register. busy=1 from the next cycle.
  - If hold=0 at acceptance, go to START; data_out=0 from the next cycle.
  - If hold=1, go to HOLD_WAIT; line stays high. Leave for START the cycle after hold is seen low.
- hold is evaluated only before the start bit; asserting it mid-frame never truncates or stretches a frame.
- send while busy=1 is ignored; there is no queueing and the latched data is unchanged.
- Bit timing: the baud counter runs 0..CLKS_PER_BIT-1 and is cleared on every state entry. Each bit lasts exactly CLKS_PER_BIT cycles.
- DATA: shift right on each bit boundary; the bit index counts 0..DATA_BITS-1.
- Parity bit: even = XOR of the latched data; odd = inverted XOR.
- STOP: data_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles, measured from the first start-bit cycle.
- Completion: on the final stop-bit cycle boundary, go to IDLE; that cycle busy=0 and done=1.
  - A send in that cycle is accepted, so back-to-back frames are separated by exactly one extra idle-high clock.
- data_out is registered (no combinational path from inputs).
- Illegal parameter values stop elaboration with an error.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port break_req (1 bit).
  - While break_req=1 and busy=0, data_out is driven 0 and send is ignored.
  - break_req has no effect while busy=1; a break never interrupts a frame.
  - Deasserting break_req returns the line high on the next cycle.
- Undefined: no port and no logic; behaviour is exactly as above.

Decomposition:
- Package uart_cfg_pkg holds:
  - the state enum;
  - parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - a function frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS) shared with the planned matching receiver.
- One sub-module, uart_baud_gen: counter with a clear input and a bit_tick output pulsed at CLKS_PER_BIT-1.

Test Plan:
- CLKS_PER_BIT=4, 8N1, send 0xA5 with hold=0 -> data_out sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high 40 cycles; done pulses once at the end.
- PARITY_MODE=1, send 0x07 -> parity bit 1. PARITY_MODE=2, send 0x07 -> parity bit 0. Both frames 44 cycles.
- hold=1 at send of 0x3C, released 20 cycles later -> line high throughout; start bit begins 1 cycle after the release; frame content correct.
- Second send (0xFF) 10 cycles into a frame of 0x00 -> ignored; only 0x00 transmitted. A send on the done cycle is accepted, with a 1-cycle idle gap.
- reset asserted mid-DATA -> data_out=1, busy=0 immediately; a subsequent send of 0x55 produces a clean full frame.
- STOP_BITS=2, DATA_BITS=7 -> stop high for 8 cycles. With UART_TX_BREAK_EN, break_req held 30 cycles while idle -> line low 30 cycles and send ignored during that time.
